// File: rtl/ld_pkg.sv
// Shared definitions for the distance-frame parser.
// Holds the FSM state encoding and the frame header/length constants.
// Also holds the output width and the distance saturation helper.
package ld_pkg;

  typedef enum logic [2:0] {
    S_H0,
    S_H1,
    S_CMD,
    S_LEN,
    S_D2,
    S_D1,
    S_D0,
    S_CS
  } state_t;

  localparam logic [7:0] HDR0     = 8'hAA;
  localparam logic [7:0] HDR1     = 8'h55;
  localparam logic [7:0] LEN_DIST = 8'h03;
  localparam int         DIST_W   = 20;

  // The payload carries 24 bits but the output is 20 bits wide. Any
  // distance that does not fit is clamped to all-ones, not truncated.
  function automatic logic [DIST_W-1:0] sat_dist(input logic [7:0] d2,
                                                 input logic [7:0] d1,
                                                 input logic [7:0] d0);
    if (d2[7:4] != 4'h0) sat_dist = {DIST_W{1'b1}};
    else                 sat_dist = {d2[3:0], d1, d0};
  endfunction

endpackage

// File: rtl/ld_frame_parser.sv
// Parses UART distance frames AA 55 CMD LEN D2 D1 D0 CS into a 20-bit distance.
// Latency: the data/vld/err outputs update 1 cycle after the accepting byte strobe.
// No backpressure: one byte may arrive every cycle. Idle gaps inside a frame time out.
// Ports: i_sys_clk, i_reset_n (async, active-low), i_en, i_rx_data/i_rx_vld (byte strobe),
//        o_jl_data/o_jl_data_vld (distance + pulse), o_frame_err, o_timeout (pulses).
module ld_frame_parser
  import ld_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] CMD_DIST    = 8'h01
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_vld,
  output logic [DIST_W-1:0] o_jl_data,
  output logic              o_jl_data_vld,
  output logic              o_frame_err,
  output logic              o_timeout
);

  localparam int             GAP_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] TO_MAX = GAP_W'(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          d2_q, d2_d;
  logic [7:0]          d1_q, d1_d;
  logic [7:0]          d0_q, d0_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DIST_W-1:0]   data_d;
  logic                vld_d, err_d, to_d;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_H0;
      sum_q         <= '0;
      cmd_q         <= '0;
      d2_q          <= '0;
      d1_q          <= '0;
      d0_q          <= '0;
      gap_q         <= '0;
      o_jl_data     <= '0;
      o_jl_data_vld <= 1'b0;
      o_frame_err   <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      cmd_q         <= cmd_d;
      d2_q          <= d2_d;
      d1_q          <= d1_d;
      d0_q          <= d0_d;
      gap_q         <= gap_d;
      o_jl_data     <= data_d;
      o_jl_data_vld <= vld_d;
      o_frame_err   <= err_d;
      o_timeout     <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cmd_d   = cmd_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    gap_d   = gap_q;
    data_d  = o_jl_data;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;

    if (!i_en) begin
      // Disabling abandons any partial frame silently.
      state_d = S_H0;
      gap_d   = '0;
    end else if (i_rx_vld) begin
      // A byte always restarts the gap timer, so a byte arriving on the
      // timeout cycle wins over the timeout.
      gap_d = '0;
      unique case (state_q)
        S_H0: if (i_rx_data == HDR0) state_d = S_H1;
        S_H1: begin
          if      (i_rx_data == HDR1) state_d = S_CMD;
          else if (i_rx_data == HDR0) state_d = S_H1;   // resync on repeated AA
          else                        state_d = S_H0;
        end
        S_CMD: begin
          cmd_d   = i_rx_data;
          sum_d   = i_rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          sum_d = sum_q + i_rx_data;
          if (i_rx_data == LEN_DIST) state_d = S_D2;
          else begin
            state_d = S_H0;
            err_d   = 1'b1;
          end
        end
        S_D2: begin
          d2_d    = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = S_D1;
        end
        S_D1: begin
          d1_d    = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = S_D0;
        end
        S_D0: begin
          d0_d    = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = S_CS;
        end
        S_CS: begin
          state_d = S_H0;
          if (i_rx_data == sum_q && cmd_q == CMD_DIST) begin
            data_d = sat_dist(d2_q, d1_q, d0_q);
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_H0;
      endcase
    end else if (state_q != S_H0) begin
      if (gap_q == TO_MAX) begin
        state_d = S_H0;
        gap_d   = '0;
        to_d    = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

endmodule
